// File: rtl/uart_resp_pkg.sv
// Shared constants and types for the UART acknowledgement formatter.
// Frame length depends on UART_RESP_CRLF_EN (defined: CR LF appended).
package uart_resp_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    localparam logic [7:0] TAG_C    = 8'h43;
    localparam logic [7:0] TAG_R    = 8'h52;
    localparam logic [7:0] TAG_M    = 8'h4D;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;

    // Pending-bit positions, also the service order (lowest index first).
    localparam int unsigned PEND_CLR  = 0;
    localparam int unsigned PEND_ENA  = 1;
    localparam int unsigned PEND_MODE = 2;

`ifdef UART_RESP_CRLF_EN
    localparam int unsigned FRAME_LEN = 5;
`else
    localparam int unsigned FRAME_LEN = 3;
`endif

    localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

endpackage

// File: rtl/uart_response_nibble.sv
// Combinational 4-bit to uppercase hex ASCII converter.
module nibble_to_ascii (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    // 0-9 map onto '0'..'9', 10-15 onto 'A'..'F'.
    always_comb begin
        if (nibble < 4'd10) ascii = 8'h30 + {4'h0, nibble};
        else                ascii = 8'h37 + {4'h0, nibble};
    end

endmodule

// File: rtl/uart_response.sv
// Formats one ASCII acknowledgement frame (tag, two hex digits of a status
// snapshot, optional CR LF when UART_RESP_CRLF_EN is defined) per command
// event and feeds it byte by byte to the UART TX handshake.
//
// state | meaning
// IDLE  | no frame active; picks the highest-priority pending command
// START | byte[idx] ready; pulses tx_start once the transmitter is free
// WAIT  | byte handed off; waits for tx_done to advance or finish
module uart_response
    import uart_resp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_enable,
    input  logic       cmd_mode,
    input  logic       cmd_clear,
    input  logic [7:0] status,
    input  logic       tx_busy,
    input  logic       tx_done,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       resp_busy,
    output logic       drop
);

    state_t     state;
    state_t     state_next;
    logic [2:0] pending;
    logic [2:0] idx;
    logic [7:0] snap;
    logic [7:0] tag;
    logic [2:0] ev;
    logic [2:0] sel;
    logic [7:0] sel_tag;
    logic       select;
    logic [2:0] clr_mask;
    logic [7:0] hex_hi;
    logic [7:0] hex_lo;
    logic [7:0] frame_byte;

    assign ev       = {cmd_mode, cmd_enable, cmd_clear};
    assign select   = (state == IDLE) && (pending != 3'b000);
    assign clr_mask = select ? sel : 3'b000;

    nibble_to_ascii u_hex_hi (.nibble(snap[7:4]), .ascii(hex_hi));
    nibble_to_ascii u_hex_lo (.nibble(snap[3:0]), .ascii(hex_lo));

    // Priority pick among pending commands: clear, then enable, then mode.
    always_comb begin
        sel     = 3'b000;
        sel_tag = TAG_C;
        if (pending[PEND_CLR]) begin
            sel[PEND_CLR] = 1'b1;
            sel_tag       = TAG_C;
        end else if (pending[PEND_ENA]) begin
            sel[PEND_ENA] = 1'b1;
            sel_tag       = TAG_R;
        end else if (pending[PEND_MODE]) begin
            sel[PEND_MODE] = 1'b1;
            sel_tag        = TAG_M;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Next-state logic; tx_done outside WAIT is ignored.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pending != 3'b000) state_next = START;
            START:   if (!tx_busy) state_next = WAIT;
            WAIT:    if (tx_done) state_next = (idx == LAST_IDX) ? IDLE : START;
            default: state_next = IDLE;
        endcase
    end

    // Pending bits, drop flag, frame snapshot and byte index. A new event
    // wins over the clear issued by selection in the same cycle, so that
    // event gets its own frame and is not counted as a merge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pending <= 3'b000;
            drop    <= 1'b0;
            idx     <= 3'd0;
            snap    <= 8'h00;
            tag     <= 8'h00;
        end else begin
            pending <= (pending & ~clr_mask) | ev;
            drop    <= |(ev & pending & ~clr_mask);
            if (select) begin
                snap <= status;
                tag  <= sel_tag;
                idx  <= 3'd0;
            end else if (state == WAIT && tx_done && idx != LAST_IDX) begin
                idx <= idx + 3'd1;
            end
        end
    end

    // Byte selection for the current frame position.
    always_comb begin
        case (idx)
            3'd0:    frame_byte = tag;
            3'd1:    frame_byte = hex_hi;
            3'd2:    frame_byte = hex_lo;
`ifdef UART_RESP_CRLF_EN
            3'd3:    frame_byte = ASCII_CR;
            3'd4:    frame_byte = ASCII_LF;
`endif
            default: frame_byte = 8'h00;
        endcase
    end

    // Outputs; tx_data holds the byte from START through WAIT.
    always_comb begin
        tx_start  = (state == START) && !tx_busy;
        tx_data   = (state == IDLE) ? 8'h00 : frame_byte;
        resp_busy = (state != IDLE) || (pending != 3'b000);
    end

endmodule

// File: tb/tb_uart_response.sv
// Directed bench for uart_response with a simple UART TX responder.
module tb_uart_response;

`ifdef UART_RESP_CRLF_EN
    localparam int FL = 5;
`else
    localparam int FL = 3;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_enable = 1'b0;
    logic       cmd_mode = 1'b0;
    logic       cmd_clear = 1'b0;
    logic [7:0] status = 8'h00;
    logic       tx_busy;
    logic       tx_done = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       resp_busy;
    logic       drop;

    logic model_busy = 1'b0;
    logic force_busy = 1'b0;
    assign tx_busy = model_busy | force_busy;

    uart_response dut (
        .clk(clk), .rst(rst),
        .cmd_enable(cmd_enable), .cmd_mode(cmd_mode), .cmd_clear(cmd_clear),
        .status(status), .tx_busy(tx_busy), .tx_done(tx_done),
        .tx_start(tx_start), .tx_data(tx_data),
        .resp_busy(resp_busy), .drop(drop)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [7:0] log_q[$];
    int         st_q[$];
    logic [7:0] exp_q[$];
    int         drop_cnt = 0;
    int         drop_cyc = -1;
    int         b2b_cnt = 0;
    logic       prev_start = 1'b0;
    bit         started = 0;
    int         cnt = 0;

    // TX responder: busy for two cycles after a start, then a done pulse.
    always @(negedge clk) begin : mdl
        logic s;
        #2;
        s = tx_start;
        if (s) begin
            log_q.push_back(tx_data);
            st_q.push_back(cyc);
        end
        if (s && prev_start) b2b_cnt++;
        prev_start = s;
        if (drop) begin
            drop_cnt++;
            drop_cyc = cyc;
        end
        tx_done = 1'b0;
        if (started) begin
            model_busy = 1'b1;
            started = 0;
            cnt = 2;
        end else if (cnt > 0) begin
            cnt--;
            if (cnt == 0) begin
                model_busy = 1'b0;
                tx_done = 1'b1;
            end
        end
        if (s) started = 1;
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic add_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_q.push_back(a);
        exp_q.push_back(b);
        exp_q.push_back(c);
`ifdef UART_RESP_CRLF_EN
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
`endif
    endtask

    task automatic clear_logs();
        log_q.delete();
        st_q.delete();
        exp_q.delete();
        drop_cnt = 0;
        drop_cyc = -1;
    endtask

    task automatic wait_quiet(output bit ok);
        int q;
        ok = 0;
        q = 0;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (!resp_busy && !started && cnt == 0 && !model_busy) q++;
            else q = 0;
            if (q >= 4) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got=%b want=0", tx_start); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL reset_tx_data got=%h want=00", tx_data); end
        checks++; if (resp_busy !== 1'b0) begin errors++; $display("FAIL reset_resp_busy got=%b want=0", resp_busy); end
        checks++; if (drop !== 1'b0) begin errors++; $display("FAIL reset_drop got=%b want=0", drop); end
        tick();
        rst = 1'b1;
        repeat (3) tick();
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL release_tx_start got=%b want=0", tx_start); end
        checks++; if (resp_busy !== 1'b0) begin errors++; $display("FAIL release_resp_busy got=%b want=0", resp_busy); end
        checks++; if (log_q.size() !== 0) begin errors++; $display("FAIL release_no_bytes got=%0d want=0", log_q.size()); end
    endtask

    task automatic test_single_enable();
        int n;
        bit ok;
        clear_logs();
        add_frame(8'h52, 8'h33, 8'h41);
        tick();
        status = 8'h3A;
        cmd_enable = 1'b1;
        n = cyc;
        tick();
        cmd_enable = 1'b0;
        wait_quiet(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL single_timeout got=%b want=1", ok); end
        checks++; if (st_q.size() < 1 || st_q[0] !== n + 2) begin errors++; $display("FAIL single_latency got=%0d want=%0d", (st_q.size() > 0) ? st_q[0] - n : -1, 2); end
        checks++; if (log_q.size() !== exp_q.size()) begin errors++; $display("FAIL single_len got=%0d want=%0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL single_byte%0d got=%h want=%h", i, log_q[i], exp_q[i]); end
        end
        checks++; if (st_q.size() < 2 || st_q[1] - st_q[0] !== 4) begin errors++; $display("FAIL single_gap got=%0d want=4", (st_q.size() > 1) ? st_q[1] - st_q[0] : -1); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_logs();
        add_frame(8'h43, 8'h30, 8'h30);
        add_frame(8'h4D, 8'h30, 8'h30);
        tick();
        status = 8'h00;
        cmd_clear = 1'b1;
        cmd_mode = 1'b1;
        tick();
        cmd_clear = 1'b0;
        cmd_mode = 1'b0;
        wait_quiet(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL b2b_timeout got=%b want=1", ok); end
        checks++; if (log_q.size() !== exp_q.size()) begin errors++; $display("FAIL b2b_len got=%0d want=%0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_byte%0d got=%h want=%h", i, log_q[i], exp_q[i]); end
        end
        checks++; if (drop_cnt !== 0) begin errors++; $display("FAIL b2b_drop got=%0d want=0", drop_cnt); end
        checks++; if (st_q.size() <= FL || st_q[FL] - st_q[FL-1] !== 5) begin errors++; $display("FAIL b2b_frame_gap got=%0d want=5", (st_q.size() > FL) ? st_q[FL] - st_q[FL-1] : -1); end
        checks++; if (b2b_cnt !== 0) begin errors++; $display("FAIL consecutive_start got=%0d want=0", b2b_cnt); end
    endtask

    task automatic test_busy_stall();
        int n;
        bit ok;
        clear_logs();
        add_frame(8'h52, 8'h35, 8'h46);
        tick();
        status = 8'h5F;
        force_busy = 1'b1;
        cmd_enable = 1'b1;
        n = cyc;
        for (int i = 1; i <= 20; i++) begin
            tick();
            cmd_enable = 1'b0;
            if (i == 3) status = 8'h00;
            if (i == 20) force_busy = 1'b0;
        end
        wait_quiet(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_timeout got=%b want=1", ok); end
        checks++; if (st_q.size() < 1 || st_q[0] !== n + 20) begin errors++; $display("FAIL stall_start got=%0d want=20", (st_q.size() > 0) ? st_q[0] - n : -1); end
        checks++; if (log_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_len got=%0d want=%0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_byte%0d got=%h want=%h", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_merge();
        int p2;
        int k;
        bit ok;
        clear_logs();
        add_frame(8'h52, 8'h37, 8'h45);
        add_frame(8'h52, 8'h37, 8'h45);
        tick();
        status = 8'h7E;
        cmd_enable = 1'b1;
        tick();
        cmd_enable = 1'b0;
        k = 0;
        while (st_q.size() < 1 && k < 100) begin
            tick();
            k++;
        end
        checks++; if (st_q.size() < 1) begin errors++; $display("FAIL merge_first_start got=%0d want=1", st_q.size()); end
        cmd_enable = 1'b1;
        tick();
        cmd_enable = 1'b0;
        tick();
        cmd_enable = 1'b1;
        p2 = cyc;
        tick();
        cmd_enable = 1'b0;
        wait_quiet(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL merge_timeout got=%b want=1", ok); end
        checks++; if (drop_cnt !== 1) begin errors++; $display("FAIL merge_drop_count got=%0d want=1", drop_cnt); end
        checks++; if (drop_cyc !== p2 + 1) begin errors++; $display("FAIL merge_drop_cycle got=%0d want=%0d", drop_cyc, p2 + 1); end
        checks++; if (log_q.size() !== exp_q.size()) begin errors++; $display("FAIL merge_len got=%0d want=%0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL merge_byte%0d got=%h want=%h", i, log_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_mid_reset();
        int k;
        bit ok;
        clear_logs();
        tick();
        status = 8'h12;
        cmd_enable = 1'b1;
        tick();
        cmd_enable = 1'b0;
        k = 0;
        while (st_q.size() < 2 && k < 100) begin
            tick();
            k++;
        end
        checks++; if (st_q.size() !== 2) begin errors++; $display("FAIL midrst_two_starts got=%0d want=2", st_q.size()); end
        cmd_mode = 1'b1;
        tick();
        cmd_mode = 1'b0;
        rst = 1'b0;
        #1;
        checks++; if (tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start got=%b want=0", tx_start); end
        checks++; if (resp_busy !== 1'b0) begin errors++; $display("FAIL midrst_resp_busy got=%b want=0", resp_busy); end
        checks++; if (tx_data !== 8'h00) begin errors++; $display("FAIL midrst_tx_data got=%h want=00", tx_data); end
        checks++; if (log_q.size() < 2 || log_q[0] !== 8'h52 || log_q[1] !== 8'h31) begin errors++; $display("FAIL midrst_partial_bytes got=%0d want=2 bytes 52 31", log_q.size()); end
        repeat (2) tick();
        rst = 1'b1;
        repeat (40) tick();
        checks++; if (st_q.size() !== 2) begin errors++; $display("FAIL midrst_no_more got=%0d want=2", st_q.size()); end
        checks++; if (resp_busy !== 1'b0) begin errors++; $display("FAIL midrst_idle_after got=%b want=0", resp_busy); end
        clear_logs();
        add_frame(8'h43, 8'h41, 8'h30);
        status = 8'hA0;
        cmd_clear = 1'b1;
        tick();
        cmd_clear = 1'b0;
        wait_quiet(ok);
        checks++; if (ok !== 1'b1) begin errors++; $display("FAIL midrst_new_timeout got=%b want=1", ok); end
        checks++; if (log_q.size() !== exp_q.size()) begin errors++; $display("FAIL midrst_new_len got=%0d want=%0d", log_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            checks++;
            if (log_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_new_byte%0d got=%h want=%h", i, log_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_single_enable();
        test_back_to_back();
        test_busy_stall();
        test_merge();
        test_mid_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
